// File: rtl/bram_frame_reader.sv
// Raster-scans one IMG_W x IMG_H frame from a 1-cycle-latency BRAM port into a valid/ready pixel stream.
// Optional stall counter output is enabled by defining BRAM_READER_STALL_CNT_EN.
module bram_frame_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_ce,
    output logic                  bram_we,
    output logic [DATA_WIDTH-1:0] bram_d,
    input  logic [DATA_WIDTH-1:0] bram_q,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_eol,
`ifdef BRAM_READER_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic                  m_eof
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t                state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  infl;
    logic                  infl_eol;
    logic                  infl_eof;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_eol;
    logic [1:0]            buf_eof;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            buf_cnt;

    logic                  pop;
    logic                  issue_eol;
    logic                  issue_eof;
    logic [2:0]            occ;

    // occ is the buffer occupancy after this edge; a read issued now lands one edge later,
    // so issuing only while occ < 2 guarantees the 2-entry buffer never overflows.
    always_comb begin
        pop       = m_valid && m_ready;
        occ       = {1'b0, buf_cnt} + {2'b0, infl} - {2'b0, pop};
        bram_ce   = (state == ISSUE) && (occ < 3'd2);
        issue_eol = (col == CW'(IMG_W - 1));
        issue_eof = issue_eol && (row == RW'(IMG_H - 1));
    end

    assign bram_we = 1'b0;
    assign bram_d  = '0;
    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = buf_data[rd_ptr];
    assign m_eol   = buf_eol[rd_ptr];
    assign m_eof   = buf_eof[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bram_addr   <= '0;
            col         <= '0;
            row         <= '0;
            infl        <= 1'b0;
            infl_eol    <= 1'b0;
            infl_eof    <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_eol     <= '0;
            buf_eof     <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            buf_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ISSUE;
                        bram_addr <= base_addr;
                        col       <= '0;
                        row       <= '0;
                    end
                end
                ISSUE: if (bram_ce && issue_eof) state <= DRAIN;
                DRAIN: if (pop && m_eof) state <= FIN;
                FIN:   state <= IDLE;
                default: state <= IDLE;
            endcase

            // Markers are computed at issue time and ride along with the read.
            if (bram_ce) begin
                bram_addr <= bram_addr + 1'b1;
                if (issue_eol) begin
                    col <= '0;
                    row <= issue_eof ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            infl     <= bram_ce;
            infl_eol <= issue_eol;
            infl_eof <= issue_eof;

            if (infl) begin
                buf_data[wr_ptr] <= bram_q;
                buf_eol[wr_ptr]  <= infl_eol;
                buf_eof[wr_ptr]  <= infl_eof;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;

            case ({infl, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

`ifdef BRAM_READER_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (m_valid && !m_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bram_frame_reader.sv
// Randomized self-checking bench for bram_frame_reader on a 4x2 frame, compared against
// an expected-pixel queue derived from the BRAM contents and the raster order.
module tb_bram_frame_reader;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, bram_ce, bram_we, m_valid, m_eol, m_eof;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_d, bram_q, m_data;
`ifdef BRAM_READER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    logic [DW-1:0] mem [1 << AW];
    int            n_vec = 0;
    int            n_err = 0;

    bram_frame_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .IMG_W(W),
        .IMG_H(H)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .base_addr(base_addr),
        .busy(busy),
        .done(done),
        .bram_addr(bram_addr),
        .bram_ce(bram_ce),
        .bram_we(bram_we),
        .bram_d(bram_d),
        .bram_q(bram_q),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_eol(m_eol),
`ifdef BRAM_READER_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .m_eof(m_eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bram_ce && !bram_we) bram_q <= mem[bram_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ready_of(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 2) == 0;
            2:       return c >= 20;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // mode: 0 always ready, 1 toggling, 2 held low 20 cycles, 3 random.
    // abort_at >= 0 pulls reset after that many handshakes; poke_start pulses start mid-frame and in FIN.
    task automatic run_frame(input logic [AW-1:0] base, input int mode, input int abort_at, input bit poke_start);
        logic [DW+1:0] expq[$];
        logic [DW+1:0] got;
        logic [DW+1:0] prev = '0;
        logic [AW-1:0] a;
        bit prev_stall = 1'b0;
        int c = 0, npop = 0, nissue = 0, ndone = 0, ce_early = 0;
        int first_pop = -1, last_pop = -1, eof_c = -2, tail = -1;

        for (int k = 0; k < N; k++) begin
            a = base + AW'(k);
            expq.push_back({k == N - 1, (k % W) == W - 1, mem[a]});
        end

        @(negedge clk);
        base_addr = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = AW'($urandom);

        while (1) begin
            start = 1'b0;
            m_ready = ready_of(mode, c);
            #1;
            if (c == 0) begin
                check("ce_latency", {31'b0, bram_ce}, 1);
                check("busy_on_start", {31'b0, busy}, 1);
            end
            if (c <= 1) check("valid_early", {31'b0, m_valid}, 0);
            if (c == 2) check("valid_latency", {31'b0, m_valid}, 1);
            check("write_port_idle", {23'b0, bram_we, bram_d}, 0);
            if (bram_ce) begin
                a = base + AW'(nissue);
                check("read_addr", {20'b0, bram_addr}, {20'b0, a});
                nissue++;
                if (c < 20) ce_early++;
            end
            if (mode == 2 && c == 19) begin
                check("ce_pulses_stalled", ce_early, 2);
                check("buffer_holding", {31'b0, m_valid}, 1);
            end
            got = {m_eof, m_eol, m_data};
            if (prev_stall) check("hold_while_stalled", {22'b0, got}, {22'b0, prev});
            prev_stall = m_valid && !m_ready;
            prev = got;
            if (done) begin
                ndone++;
                check("done_latency", c, eof_c + 1);
                tail = c;
            end
            if (m_valid && m_ready) begin
                if (expq.size() == 0) check("extra_pixel", 1, 0);
                else check("pixel", {22'b0, got}, {22'b0, expq.pop_front()});
                if (first_pop < 0) first_pop = c;
                last_pop = c;
                npop++;
                if (m_eof) eof_c = c;
            end
            if (abort_at >= 0 && npop == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("reset_outputs", {6'b0, busy, done, bram_ce, m_valid, m_eol, m_eof, bram_addr, m_data}, 0);
                @(negedge clk);
                reset_n = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check("no_done_after_abort", {30'b0, done, busy}, 0);
                end
                return;
            end
            if (poke_start && (c == 4 || done)) begin
                start = 1'b1;
                base_addr = AW'($urandom);
            end
            if (tail >= 0 && c == tail + 2) begin
                check("idle_after_done", {31'b0, busy}, 0);
                break;
            end
            if (c > 300) begin
                check("timeout", 0, 1);
                break;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        check("done_count", ndone, 1);
        check("pixels_popped", npop, N);
        check("reads_issued", nissue, N);
        if (mode == 0) check("back_to_back", last_pop - first_pop, N - 1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
        #1;
        check("reset_state", {6'b0, busy, done, bram_ce, m_valid, m_eol, m_eof, bram_addr, m_data}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_frame(12'h010, 0, -1, 1'b0);
        run_frame(12'h010, 1, -1, 1'b0);
`ifdef BRAM_READER_STALL_CNT_EN
        check("stall_cnt", {16'b0, stall_cnt}, 7);
`endif
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        run_frame(12'hFFE, 0, -1, 1'b0);
        run_frame(AW'($urandom), 2, -1, 1'b0);
        run_frame(AW'($urandom), 0, -1, 1'b1);
        run_frame(AW'($urandom), 0, 3, 1'b0);
        run_frame(AW'($urandom), 0, -1, 1'b0);
        for (int f = 0; f < 6; f++) run_frame(AW'($urandom), 3, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
